// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular {PC, instruction} FIFO between fetch and decode with
//               flush on branch redirect. Optional FETCHQ_BYPASS_EN macro adds
//               a zero-cycle enq->deq path when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_F,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [N-1:0]             enq_pc,
    input  logic [31:0]              enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [N-1:0]             deq_pc,
    output logic [31:0]              deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   c_full = (AW+1)'(DEPTH);

    logic [N-1:0]  r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_pass;
    logic w_enq_fire;
    logic w_deq_fire;

    assign w_empty   = (r_count == '0);
    assign enq_ready = (r_count != c_full);
    assign count     = r_count;

`ifdef FETCHQ_BYPASS_EN
    // Empty queue: the fetched pair is presented straight to decode; if decode
    // takes it in the same cycle it is never stored.
    assign w_pass    = w_empty & enq_valid & deq_ready & ~flush_F;
    assign deq_valid = w_empty ? (enq_valid & ~flush_F) : 1'b1;
    assign deq_pc    = w_empty ? enq_pc    : r_pc_mem[r_rd_ptr];
    assign deq_instr = w_empty ? enq_instr : r_instr_mem[r_rd_ptr];
`else
    assign w_pass    = 1'b0;
    assign deq_valid = ~w_empty;
    assign deq_pc    = r_pc_mem[r_rd_ptr];
    assign deq_instr = r_instr_mem[r_rd_ptr];
`endif

    assign w_enq_fire = enq_valid & enq_ready & ~flush_F & ~w_pass;
    assign w_deq_fire = ~w_empty & deq_ready & ~flush_F;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (flush_F) begin
            // Storage is intentionally left intact; only the pointers matter.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_pc_mem[r_wr_ptr]    <= enq_pc;
                r_instr_mem[r_wr_ptr] <= enq_instr;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            if (w_deq_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush_F;
    logic        enq_valid;
    logic        enq_ready;
    logic [63:0] enq_pc;
    logic [31:0] enq_instr;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  count;

    int checks;
    int failures;

    fetch_queue #(.N(64), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_F   (flush_F),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [63:0] pc, input logic [31:0] instr);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_instr = instr;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        enq_valid = 1'b1;
        enq_pc    = 64'h1234;
        enq_instr = 32'hDEAD_BEEF;
        tick();
        tick();
        reset     = 1'b1;
        enq_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_deq_valid got=%b exp=0", deq_valid);
        end
        checks++;
        if (enq_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_enq_ready got=%b exp=1", enq_ready);
        end
        checks++;
        if (deq_pc !== 64'h0 || deq_instr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got pc=%h instr=%h exp 0/0", deq_pc, deq_instr);
        end
    endtask

    task automatic test_fill_drain;
        deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (enq_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_enq_ready[%0d] got=%b exp=1", i, enq_ready);
            end
            enq_one(64'(4 * i), 32'h8B00_0000 + 32'(i));
        end
        checks++;
        if (count !== 3'd4 || enq_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state got count=%0d enq_ready=%b exp 4/0", count, enq_ready);
        end
        enq_one(64'h10, 32'h8B00_0004);
        checks++;
        if (count !== 3'd4 || deq_pc !== 64'h0) begin
            failures++;
            $display("FAIL full_reject got count=%0d head=%h exp 4/0", count, deq_pc);
        end
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 64'(4 * i) ||
                deq_instr !== 32'h8B00_0000 + 32'(i)) begin
                failures++;
                $display("FAIL drain[%0d] got v=%b pc=%h instr=%h exp 1/%h/%h", i,
                         deq_valid, deq_pc, deq_instr, 64'(4 * i), 32'h8B00_0000 + 32'(i));
            end
            tick();
        end
        deq_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got count=%0d v=%b exp 0/0", count, deq_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_pc;
        deq_ready = 1'b0;
        enq_one(64'h20, 32'h0000_0020);
        enq_one(64'h24, 32'h0000_0024);
        deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_pc    = 64'h20 + 64'(4 * i);
            enq_valid = 1'b1;
            enq_pc    = 64'h28 + 64'(4 * i);
            enq_instr = 32'h28 + 32'(4 * i);
            #1;
            checks++;
            if (deq_valid !== 1'b1 || deq_pc !== exp_pc || deq_instr !== exp_pc[31:0]) begin
                failures++;
                $display("FAIL b2b_head[%0d] got v=%b pc=%h instr=%h exp pc=%h", i,
                         deq_valid, deq_pc, deq_instr, exp_pc);
            end
            tick();
            checks++;
            if (count !== 3'd2) begin
                failures++;
                $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count);
            end
        end
        enq_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_pc = 64'h38 + 64'(4 * i);
            checks++;
            if (deq_valid !== 1'b1 || deq_pc !== exp_pc) begin
                failures++;
                $display("FAIL b2b_tail[%0d] got v=%b pc=%h exp pc=%h", i, deq_valid, deq_pc, exp_pc);
            end
            tick();
        end
        deq_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_empty got=%0d exp=0", count);
        end
    endtask

    task automatic test_flush;
        deq_ready = 1'b0;
        enq_one(64'h50, 32'h50);
        enq_one(64'h54, 32'h54);
        enq_one(64'h58, 32'h58);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre_count got=%0d exp=3", count);
        end
        flush_F   = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 64'h100;
        enq_instr = 32'h100;
        deq_ready = 1'b1;
        tick();
        flush_F   = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty got count=%0d v=%b exp 0/0", count, deq_valid);
        end
        enq_one(64'h200, 32'h200);
        checks++;
        if (count !== 3'd1 || deq_valid !== 1'b1 || deq_pc !== 64'h200) begin
            failures++;
            $display("FAIL flush_next got count=%0d v=%b pc=%h exp 1/1/200", count, deq_valid, deq_pc);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drain got count=%0d v=%b exp 0/0", count, deq_valid);
        end
    endtask

    task automatic test_latency;
        enq_valid = 1'b1;
        enq_pc    = 64'h40;
        enq_instr = 32'h40;
        deq_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        checks++;
        if (deq_valid !== 1'b1 || deq_pc !== 64'h40) begin
            failures++;
            $display("FAIL bypass_same_cycle got v=%b pc=%h exp 1/40", deq_valid, deq_pc);
        end
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_count got count=%0d v=%b exp 0/0", count, deq_valid);
        end
`else
        checks++;
        if (deq_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_same_cycle got v=%b exp 0", deq_valid);
        end
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++;
        if (deq_valid !== 1'b1 || deq_pc !== 64'h40 || count !== 3'd1) begin
            failures++;
            $display("FAIL latency_next got v=%b pc=%h count=%0d exp 1/40/1", deq_valid, deq_pc, count);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
`endif
    endtask

    task automatic test_mid_reset;
        deq_ready = 1'b0;
        enq_one(64'h300, 32'h300);
        enq_one(64'h304, 32'h304);
        enq_one(64'h308, 32'h308);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL mreset_pre got=%0d exp=3", count);
        end
        reset     = 1'b0;
        flush_F   = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 64'h30C;
        deq_ready = 1'b1;
        tick();
        reset     = 1'b1;
        flush_F   = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0 || deq_pc !== 64'h0) begin
            failures++;
            $display("FAIL mreset_state got count=%0d v=%b pc=%h exp 0/0/0", count, deq_valid, deq_pc);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        flush_F   = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_instr = '0;
        deq_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_latency();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
